// File: rtl/hit_mask_serializer.sv
// Drains a multi-hot hit mask as a stream of one-hot codes plus binary indices,
// highest channel first, with valid/ready handshakes on both the mask and hit sides.
module hit_mask_serializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             mask_valid,
  output logic             mask_ready,
  input  logic [WIDTH-1:0] mask,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic [WIDTH-1:0] hit_onehot,
  output logic [IDX_W-1:0] hit_index,
  output logic             hit_last,
  output logic             busy
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] w_pending_nxt;

  logic [IDX_W-1:0] w_top_idx;
  logic [WIDTH-1:0] w_top_onehot;
  logic             w_single;
  logic             w_hit_fire;
  logic             w_mask_fire;

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    w_top_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (r_pending[i]) w_top_idx = IDX_W'(i);
    end
  end

  always_comb begin
    w_top_onehot            = '0;
    w_top_onehot[w_top_idx] = r_pending[w_top_idx];
  end

  assign w_single = (r_pending != '0) && ((r_pending & (r_pending - WIDTH'(1))) == '0);

  assign hit_valid  = (r_state == SCAN);
  assign hit_onehot = hit_valid ? w_top_onehot : '0;
  assign hit_index  = hit_valid ? w_top_idx : '0;
  assign hit_last   = hit_valid & w_single;
  assign busy       = |r_pending;

  assign mask_ready  = !flush && ((r_state == IDLE) || (hit_valid && hit_last && hit_ready));
  assign w_hit_fire  = hit_valid && hit_ready && !flush;
  assign w_mask_fire = mask_valid && mask_ready;

  // A mask accepted on the final beat replaces the pending word outright,
  // which also retires the bit being transferred on that beat.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    if (flush) begin
      w_state_nxt   = IDLE;
      w_pending_nxt = '0;
    end else if (w_mask_fire) begin
      w_pending_nxt = mask;
      w_state_nxt   = (mask != '0) ? SCAN : IDLE;
    end else if (w_hit_fire) begin
      w_pending_nxt = r_pending & ~w_top_onehot;
      w_state_nxt   = hit_last ? IDLE : SCAN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
    end
  end

endmodule
